muldiv_ctrl: RTL

- Multi-cycle RV32M execution controller in the EX stage, beside the single-cycle ALU.
- Accepts one M-extension operation, runs an iterative shift-add multiplier or restoring divider, and stalls the pipeline until the result is ready.
- Returns the result through a one-cycle done pulse that the EX/MEM register captures in place of the ALU result.

---
 rtl/muldiv_ctrl_if.sv | 40 ++++
 rtl/muldiv_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl_if
//   Bundles the EX-stage request and response signals of the multi-cycle
//   RV32M controller. Clock and reset are not part of the bundle; they stay
//   plain ports on the design.
//
//   Request (driven by the pipeline, the master):
//     start   EX holds an M-extension instruction (level, held while stalled)
//     op      funct3 code of the M-extension instruction
//     a, b    forwarded rs1 / rs2 operands
//     flush   synchronous kill from a branch/jump redirect
//   Response (driven by the controller, the slave):
//     stall   freezes PC, IF/ID and ID/EX
//     busy    controller is iterating
//     done    one-cycle pulse, result valid
//     result  operation result
// ----------------------------------------------------------------------------
interface muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
//   Multi-cycle RV32M execution controller sitting beside the EX-stage ALU.
//   Accepts one M-extension operation, runs a 32-iteration shift-add
//   multiplier or restoring divider on operand magnitudes, applies the sign
//   correction on the last iteration and presents the result with a
//   single-cycle done pulse. Divide-by-zero and signed overflow are resolved
//   at acceptance and finish in one cycle.
//
//   Ports:
//     clk    rising-edge clock
//     rstn   asynchronous active-low reset
//     bus    muldiv_ctrl_if slave modport (start/op/a/b/flush in,
//            stall/busy/done/result out)
//
//   Build option:
//     MULDIV_FAST_MUL_EN  when defined, all four multiplies use a single-cycle
//                         combinational signed product and take the one-cycle
//                         path; division is unchanged. When undefined, no
//                         multiply operator is used.
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic          clk,
    input  logic          rstn,
    muldiv_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(ITER) + 1;

    logic [1:0]      state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [2:0]      op_q,      op_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic [XLEN-1:0] hi_q,      hi_d;
    logic [XLEN-1:0] lo_q,      lo_d;
    logic [XLEN-1:0] opnd_q,    opnd_d;
    logic            neg_q,     neg_d;
    logic            neg_rem_q, neg_rem_d;

    // ------------------------------------------------------------------
    // Operand decode at acceptance. MUL only keeps the low half, which is
    // the same for any signedness, so it is treated as unsigned.
    // ------------------------------------------------------------------
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign is_div   = bus.op[2];
    assign a_signed = (bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op[2] & ~bus.op[0]);
    assign b_signed = (bus.op == 3'b001) | (bus.op[2] & ~bus.op[0]);
    assign a_neg    = a_signed & bus.a[XLEN-1];
    assign b_neg    = b_signed & bus.b[XLEN-1];
    assign mag_a    = a_neg ? -bus.a : bus.a;
    assign mag_b    = b_neg ? -bus.b : bus.b;

    // ------------------------------------------------------------------
    // One-cycle cases decided at acceptance.
    // ------------------------------------------------------------------
    logic            div_by_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign div_by_zero = is_div & (bus.b == '0);
    assign div_ovf     = is_div & ~bus.op[0]
                       & (bus.a == {1'b1, {(XLEN-1){1'b0}}})
                       & (bus.b == '1);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending both operands to the full product width makes the
    // truncated unsigned product equal to the signed 33x33 product.
    logic [2*XLEN-1:0] fast_a;
    logic [2*XLEN-1:0] fast_b;
    logic [2*XLEN-1:0] fast_prod;

    assign fast_a    = {{XLEN{a_neg}}, bus.a};
    assign fast_b    = {{XLEN{b_neg}}, bus.b};
    assign fast_prod = fast_a * fast_b;
    assign special   = div_by_zero | div_ovf | ~is_div;
`else
    assign special   = div_by_zero | div_ovf;
`endif

    always_comb begin
        special_res = '0;
        if (div_by_zero) begin
            special_res = bus.op[1] ? bus.a : '1;
        end else if (div_ovf) begin
            special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!is_div) begin
            special_res = (bus.op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                 : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // ------------------------------------------------------------------
    // One iteration of the shared datapath.
    // Multiply: {hi,lo} holds partial product / remaining multiplier;
    //   add the multiplicand to hi when lo[0] is set, then shift right.
    // Divide: {hi,lo} holds remainder / dividend-then-quotient; shift left,
    //   trial-subtract the divisor and keep the difference if no borrow.
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q & {XLEN{lo_q[0]}}};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection applied to the values produced
    // by the final iteration, so the result registers on the same edge.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   finish_res;

    always_comb begin
        prod_mag = {step_hi, step_lo};
        prod     = neg_q ? -prod_mag : prod_mag;
        quot     = neg_q ? -step_lo : step_lo;
        rem      = neg_rem_q ? -step_hi : step_hi;
        if (op_q[2]) begin
            finish_res = op_q[1] ? rem : quot;
        end else begin
            finish_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath next-state. Flush wins over everything and
    // leaves the result untouched; start is only honoured in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_d  = bus.op;
                        cnt_d = '0;
                        if (special) begin
                            state_d  = S_DONE;
                            result_d = special_res;
                        end else begin
                            state_d   = S_BUSY;
                            hi_d      = '0;
                            lo_d      = is_div ? mag_a : mag_b;
                            opnd_d    = is_div ? mag_b : mag_a;
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                        end
                    end
                end
                S_BUSY: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d  = S_DONE;
                        result_d = finish_res;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign bus.busy   = (state_q == S_BUSY);
    assign bus.done   = (state_q == S_DONE);
    assign bus.stall  = (state_q == S_BUSY) | ((state_q == S_IDLE) & bus.start & ~bus.flush);
    assign bus.result = result_q;

endmodule
